// File: rtl/seg7_disp_arbiter.sv
// Display scheduler for the 4-digit 7-seg scanner: generates the scan tick and
// picks live value A or held message B for the digits, switching only at frame boundaries.
module seg7_disp_arbiter #(
    parameter int PRESCALE   = 12500,
    parameter int HOLD_TICKS = 2000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        a_valid,
    input  logic [15:0] a_data,
    input  logic        b_req,
    input  logic [15:0] b_data,
    output logic        b_ack,
    output logic        scan_en,
    output logic [3:0]  dig0,
    output logic [3:0]  dig1,
    output logic [3:0]  dig2,
    output logic [3:0]  dig3,
    output logic        src,
    output logic        hold_active
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int HW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
    localparam logic [PW-1:0] P_LAST = PW'(PRESCALE - 1);
    localparam logic [HW-1:0] H_LOAD = HW'(HOLD_TICKS - 1);

    typedef enum logic {SHOW_A = 1'b0, SHOW_B = 1'b1} state_t;

    state_t            state, state_nxt;
    logic [PW-1:0]     pcnt, pcnt_nxt;
    logic [2:0]        phase;
    logic [HW-1:0]     hold_cnt;
    logic [15:0]       a_shadow;
    logic [15:0]       b_reg;
    logic [3:0][3:0]   digits;
    logic              frame_bnd;
    logic              accept;
    logic              expire;

    // scan_en is registered from the next prescaler value so it is low in reset
    // and lands in the cycle where pcnt == PRESCALE-1.
    always_comb pcnt_nxt = (pcnt == P_LAST) ? '0 : pcnt + PW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt    <= '0;
            scan_en <= 1'b0;
        end else begin
            pcnt    <= pcnt_nxt;
            scan_en <= (pcnt_nxt == P_LAST);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       phase <= '0;
        else if (scan_en) phase <= phase + 3'd1;
    end

    assign frame_bnd = scan_en && (phase == 3'd7);

    // b_ack gating makes the cycle after an ack non-accepting.
    assign accept = b_req && !b_ack;
    assign expire = (state == SHOW_B) && scan_en && (hold_cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b_ack <= 1'b0;
            b_reg <= '0;
        end else begin
            b_ack <= accept;
            if (accept) b_reg <= b_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       a_shadow <= '0;
        else if (a_valid) a_shadow <= a_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            hold_cnt <= '0;
        else if (accept)
            hold_cnt <= H_LOAD;
        else if ((state == SHOW_B) && scan_en && (hold_cnt != '0))
            hold_cnt <= hold_cnt - HW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= SHOW_A;
        else        state <= state_nxt;
    end

    // A fresh accept overrides a same-cycle expiry.
    always_comb begin
        state_nxt = state;
        if (accept)      state_nxt = SHOW_B;
        else if (expire) state_nxt = SHOW_A;
    end

    always_comb begin
        hold_active = (state == SHOW_B);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digits <= '0;
            src    <= 1'b0;
        end else if (frame_bnd) begin
            digits <= (state == SHOW_B) ? b_reg : a_shadow;
            src    <= (state == SHOW_B);
        end
    end

    assign dig0 = digits[0];
    assign dig1 = digits[1];
    assign dig2 = digits[2];
    assign dig3 = digits[3];

endmodule

// File: tb/tb_seg7_disp_arbiter.sv
// Directed bench for seg7_disp_arbiter with PRESCALE=4, HOLD_TICKS=16.
module tb_seg7_disp_arbiter;

    localparam int PRESCALE = 4;
    localparam int HOLD     = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        a_valid = 1'b0;
    logic [15:0] a_data = '0;
    logic        b_req = 1'b0;
    logic [15:0] b_data = '0;
    logic        b_ack, scan_en, src, hold_active;
    logic [3:0]  dig0, dig1, dig2, dig3;

    seg7_disp_arbiter #(.PRESCALE(PRESCALE), .HOLD_TICKS(HOLD)) dut (
        .clk(clk), .rst_n(rst_n), .a_valid(a_valid), .a_data(a_data),
        .b_req(b_req), .b_data(b_data), .b_ack(b_ack), .scan_en(scan_en),
        .dig0(dig0), .dig1(dig1), .dig2(dig2), .dig3(dig3),
        .src(src), .hold_active(hold_active)
    );

    always #5 clk = ~clk;

    // Cycles since reset release; scan ticks fall on cyc%4==3, frame bounds on cyc%32==31.
    int cyc;
    always @(posedge clk or negedge rst_n)
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;
    wire [15:0] digs = {dig3, dig2, dig1, dig0};

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic wait_to(input int t);
        for (int n = 0; n < 300 && cyc != t; n++) @(negedge clk);
        chk("wait_to", 32'(cyc), 32'(t));
    endtask

    always @(negedge clk) chk("scan_en_period", 32'(scan_en), 32'(rst_n && (cyc % 4 == 3)));

    typedef struct {
        logic [15:0] d1;
        logic        two;
        logic [15:0] d2;
        logic [3:0]  e3, e2, e1, e0;
    } avec_t;

    avec_t tbl[4];

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        logic [15:0] prev;

        tbl[0] = '{16'hBEEF, 1'b0, 16'h0000, 4'hB, 4'hE, 4'hE, 4'hF};
        tbl[1] = '{16'h0F0F, 1'b1, 16'hC3A5, 4'hC, 4'h3, 4'hA, 4'h5};
        tbl[2] = '{16'hFFFF, 1'b0, 16'h0000, 4'hF, 4'hF, 4'hF, 4'hF};
        tbl[3] = '{16'h1234, 1'b0, 16'h0000, 4'h1, 4'h2, 4'h3, 4'h4};

        // reset state
        @(negedge clk); @(negedge clk);
        chk("rst_digs", 32'(digs), 32'h0);
        chk("rst_src", 32'(src), 32'h0);
        chk("rst_ack", 32'(b_ack), 32'h0);
        chk("rst_hold", 32'(hold_active), 32'h0);
        rst_n = 1'b1;
        @(negedge clk); chk("scan_c1", 32'(scan_en), 32'h0);
        @(negedge clk); chk("scan_c2", 32'(scan_en), 32'h0);
        @(negedge clk); chk("scan_c3", 32'(scan_en), 32'h1);
        @(negedge clk); chk("scan_c4", 32'(scan_en), 32'h0);

        // A path table: strobe just after a frame load, check old digits at the
        // boundary cycle and new ones right after.
        prev = 16'h0000;
        for (int i = 0; i < 4; i++) begin
            base = ((cyc + 31) / 32) * 32;
            wait_to(base);
            a_valid = 1'b1; a_data = tbl[i].d1;
            @(negedge clk);
            if (tbl[i].two) begin
                a_data = tbl[i].d2;
                @(negedge clk);
            end
            a_valid = 1'b0;
            wait_to(base + 31);
            chk("a_before_bnd", 32'(digs), 32'(prev));
            wait_to(base + 32);
            chk("a_digs", 32'(digs), 32'({tbl[i].e3, tbl[i].e2, tbl[i].e1, tbl[i].e0}));
            chk("a_src", 32'(src), 32'h0);
            prev = {tbl[i].e3, tbl[i].e2, tbl[i].e1, tbl[i].e0};
        end

        // B message, hold and expiry
        base = cyc;
        b_req = 1'b1; b_data = 16'hABCD;
        @(negedge clk);
        chk("b1_ack", 32'(b_ack), 32'h1);
        chk("b1_hold", 32'(hold_active), 32'h1);
        b_req = 1'b0;
        @(negedge clk);
        chk("b1_ack_pulse", 32'(b_ack), 32'h0);
        wait_to(base + 31);
        chk("b1_pre_digs", 32'(digs), 32'h1234);
        wait_to(base + 32);
        chk("b1_digs", 32'(digs), 32'hABCD);
        chk("b1_src", 32'(src), 32'h1);
        wait_to(base + 63);
        chk("b1_hold_last", 32'(hold_active), 32'h1);
        wait_to(base + 64);
        chk("b1_expired", 32'(hold_active), 32'h0);
        chk("b1_digs_tail", 32'(digs), 32'hABCD);
        wait_to(base + 96);
        chk("b1_back_a", 32'(digs), 32'h1234);
        chk("b1_back_src", 32'(src), 32'h0);

        // restart after 10 ticks, plus A update during SHOW_B
        base = cyc;
        b_req = 1'b1; b_data = 16'hABCD;
        @(negedge clk);
        chk("b2_ack", 32'(b_ack), 32'h1);
        b_req = 1'b0;
        wait_to(base + 40);
        b_req = 1'b1; b_data = 16'h00EF;
        @(negedge clk);
        chk("b2_reack", 32'(b_ack), 32'h1);
        b_req = 1'b0;
        wait_to(base + 50);
        a_valid = 1'b1; a_data = 16'h5678;
        @(negedge clk);
        a_valid = 1'b0;
        wait_to(base + 64);
        chk("b2_still_hold", 32'(hold_active), 32'h1);
        chk("b2_digs_ef", 32'(digs), 32'h00EF);
        wait_to(base + 96);
        chk("b2_digs_stay", 32'(digs), 32'h00EF);
        wait_to(base + 103);
        chk("b2_hold_last", 32'(hold_active), 32'h1);
        wait_to(base + 104);
        chk("b2_expired", 32'(hold_active), 32'h0);
        wait_to(base + 127);
        chk("b2_digs_b_tail", 32'(digs), 32'h00EF);
        wait_to(base + 128);
        chk("b2_digs_5678", 32'(digs), 32'h5678);
        chk("b2_src", 32'(src), 32'h0);

        // async reset mid-hold with b_req held through it
        base = cyc;
        b_req = 1'b1; b_data = 16'h1357;
        @(negedge clk);
        b_req = 1'b0;
        wait_to(base + 10);
        #2;
        b_req = 1'b1; b_data = 16'h2468; rst_n = 1'b0;
        #1;
        chk("ar_digs", 32'(digs), 32'h0);
        chk("ar_src", 32'(src), 32'h0);
        chk("ar_hold", 32'(hold_active), 32'h0);
        chk("ar_ack", 32'(b_ack), 32'h0);
        chk("ar_scan", 32'(scan_en), 32'h0);
        @(negedge clk);
        chk("ar_ack_in_rst", 32'(b_ack), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ar_ack_after", 32'(b_ack), 32'h1);
        chk("ar_hold_after", 32'(hold_active), 32'h1);
        @(negedge clk);
        chk("ar_ack_gap", 32'(b_ack), 32'h0);
        @(negedge clk);
        chk("ar_ack_again", 32'(b_ack), 32'h1);
        b_req = 1'b0;
        @(negedge clk);
        chk("ar_ack_done", 32'(b_ack), 32'h0);
        wait_to(32);
        chk("ar_digs_b", 32'(digs), 32'h2468);
        chk("ar_src_b", 32'(src), 32'h1);
        wait_to(96);
        chk("ar_shadow_clr", 32'(digs), 32'h0);
        chk("ar_src_a", 32'(src), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
